// File: rtl/flip_flop_pkg.sv
// Shared defaults for the flip_flop storage primitive.
package flip_flop_pkg;

    localparam int unsigned FF_WIDTH   = 1;
    localparam logic        FF_RST_BIT = 1'b0;

endpackage : flip_flop_pkg

// File: rtl/flip_flop.sv
// D-type register with asynchronous active-high reset and a complementary output.
module flip_flop
    import flip_flop_pkg::*;
#(
    parameter int unsigned       WIDTH   = FF_WIDTH,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{FF_RST_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_negada
);

    logic [WIDTH-1:0] r_q;

    // Reset dominates any coincident clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= D;
        end
    end

    // Complement comes from the stored state, so it can never disagree with Q.
    assign Q        = r_q;
    assign Q_negada = ~r_q;

endmodule : flip_flop

// File: tb/tb_flip_flop.sv
// Self-checking bench for flip_flop: default 1-bit instance and an 8-bit instance with a nonzero reset value.
module tb_flip_flop;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       d1;
    logic       q1;
    logic       qn1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    // Reference state: what each register should hold right now.
    logic       m1;
    logic [7:0] m8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    flip_flop u_ff1 (
        .clk      (clk),
        .rst      (rst),
        .D        (d1),
        .Q        (q1),
        .Q_negada (qn1)
    );

    flip_flop #(
        .WIDTH   (8),
        .RST_VAL (RV8)
    ) u_ff8 (
        .clk      (clk),
        .rst      (rst),
        .D        (d8),
        .Q        (q8),
        .Q_negada (qn8)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/q1"},  {7'b0, q1},  {7'b0, m1});
        chk({tag, "/qn1"}, {7'b0, qn1}, {7'b0, ~m1});
        chk({tag, "/q8"},  q8,  m8);
        chk({tag, "/qn8"}, qn8, ~m8);
    endtask

    task automatic model_reset();
        m1 = 1'b0;
        m8 = RV8;
    endtask

    // One rising edge: the model takes D unless reset is high, then outputs are checked just after the edge.
    task automatic edge_step(input string tag);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m1 = d1;
            m8 = d8;
        end
        #1;
        check_all(tag);
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        d1  = 1'b0;
        d8  = 8'h00;
        #1;
        model_reset();
        check_all("reset_no_edge");
        @(negedge clk);
        #2;

        rst = 1'b0;
        d1  = 1'b0;
        d8  = 8'h00;
        edge_step("capture0");

        d1 = 1'b1;
        d8 = 8'h3C;
        edge_step("capture1");

        d1 = 1'b0;
        d8 = 8'hFF;
        #1;
        check_all("d_toggle_hold");
        d1 = 1'b1;
        d8 = 8'h3C;

        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        edge_step("reset_hold_d1");
        d1 = 1'b0;
        d8 = 8'h77;
        edge_step("reset_hold_d0");

        rst = 1'b0;
        d1  = 1'b1;
        d8  = 8'h5A;
        #1;
        check_all("release_before_edge");
        edge_step("release_capture");

        rst = 1'b1;
        #1;
        model_reset();
        check_all("short_pulse");
        rst = 1'b0;
        #1;
        check_all("short_pulse_hold");
        edge_step("after_pulse_capture");

        for (int i = 0; i < 200; i++) begin
            d1  = 1'($urandom);
            d8  = 8'($urandom);
            rst = ($urandom_range(0, 9) == 0);
            edge_step("random");
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all("random_pulse");
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_flip_flop
